// File: rtl/multicycle_control_pkg.sv
//------------------------------------------------------------------------------
// cpu_ctrl_pkg : opcode, ALU/mux encodings, FSM states and control word for
//                the multicycle 16-bit CPU sequencer.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000100;
  localparam logic [5:0] OP_ANDI = 6'b000110;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b001000;
  localparam logic [5:0] OP_BNE  = 6'b001001;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_RFMT = 2'b10;
  localparam logic [1:0] ALUOP_IFMT = 2'b11;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFS = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // States that own a memory access and therefore the wait counter.
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_if.sv
//------------------------------------------------------------------------------
// multicycle_control_if : opcode/status inputs and datapath control outputs.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface multicycle_control_if;
  logic [5:0] Opcode;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       BranchNe;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       MemErr;
  logic [3:0] State;

  modport master (
    output Opcode, Zero, MemReady,
    input  PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           MemErr, State
  );

  modport slave (
    input  Opcode, Zero, MemReady,
    output PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           MemErr, State
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_control_mem_wait_timer.sv
//------------------------------------------------------------------------------
// mem_wait_timer : saturating wait counter with timeout compare at MEM_TIMEOUT-1.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_wait,
  output logic o_at_limit
);

  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_MAX   = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_wait && (r_cnt != C_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_limit = (r_cnt == C_LIMIT);

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
//------------------------------------------------------------------------------
// multicycle_control : main sequencing FSM of the multicycle 16-bit CPU.
// Optional macro MULTICYCLE_CTRL_ILLEGAL_TRAP_EN adds the TRAP state and Illegal.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  multicycle_control_if.slave  bus
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                 Illegal
`endif
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;
  logic   w_mem_err;
  logic   w_mem_state;
  logic   w_at_limit;
  logic   w_timeout;
  logic   w_wait;
  logic   w_clear;

  assign w_mem_state = is_mem_state(r_state);
  assign w_wait      = w_mem_state && !bus.MemReady;
  assign w_timeout   = w_wait && w_at_limit;
  // Any state change restarts the count; a timeout in FETCH re-enters FETCH.
  assign w_clear     = (w_next != r_state) || w_timeout;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk        (Clock),
    .rst        (Reset),
    .i_clear    (w_clear),
    .i_wait     (w_wait),
    .o_at_limit (w_at_limit)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_ctrl    = '0;
    w_mem_err = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_read = !w_timeout;
        if (bus.MemReady) begin
          w_ctrl.ir_write  = 1'b1;
          w_ctrl.pc_write  = 1'b1;
          w_ctrl.alu_src_b = SRCB_ONE;
          w_ctrl.alu_op    = ALUOP_ADD;
          w_ctrl.pc_source = PCSRC_ALU;
          w_next           = S_DECODE;
        end else if (w_timeout) begin
          w_mem_err = 1'b1;
          w_next    = S_FETCH;
        end
      end
      S_DECODE: begin
        w_ctrl.alu_src_b = SRCB_BOFS;
        w_ctrl.alu_op    = ALUOP_ADD;
        case (bus.Opcode)
          OP_LW, OP_SW:     w_next = S_MEMADR;
          OP_R:             w_next = S_REXEC;
          OP_ADDI, OP_ANDI: w_next = S_IEXEC;
          OP_BEQ, OP_BNE:   w_next = S_BRANCH;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          default:          w_next = S_TRAP;
`else
          default:          w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_ADD;
        w_next           = (bus.Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_ctrl.mem_read = !w_timeout;
        w_ctrl.i_or_d   = 1'b1;
        if (bus.MemReady) begin
          w_next = S_MEMWB;
        end else if (w_timeout) begin
          w_mem_err = 1'b1;
          w_next    = S_FETCH;
        end
      end
      S_MEMWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_next            = S_FETCH;
      end
      S_MEMWR: begin
        w_ctrl.mem_write = !w_timeout;
        w_ctrl.i_or_d    = 1'b1;
        if (bus.MemReady) begin
          w_next = S_FETCH;
        end else if (w_timeout) begin
          w_mem_err = 1'b1;
          w_next    = S_FETCH;
        end
      end
      S_REXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_RT;
        w_ctrl.alu_op    = ALUOP_RFMT;
        w_next           = S_RWB;
      end
      S_RWB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
        w_next           = S_FETCH;
      end
      S_IEXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_IFMT;
        w_next           = S_IWB;
      end
      S_IWB: begin
        w_ctrl.reg_write = 1'b1;
        w_next           = S_FETCH;
      end
      S_BRANCH: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_src_b     = SRCB_RT;
        w_ctrl.alu_op        = ALUOP_SUB;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_source     = PCSRC_ALUOUT;
        w_ctrl.branch_ne     = (bus.Opcode == OP_BNE);
        w_next               = S_FETCH;
      end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        w_next = S_TRAP;
      end
`endif
      default: begin
        w_next = S_FETCH;
      end
    endcase
    // Reset silences every output, including an in-flight write enable.
    if (Reset) begin
      w_ctrl    = '0;
      w_mem_err = 1'b0;
    end
  end

  assign bus.PCWrite     = w_ctrl.pc_write;
  assign bus.PCWriteCond = w_ctrl.pc_write_cond;
  assign bus.BranchNe    = w_ctrl.branch_ne;
  assign bus.IorD        = w_ctrl.i_or_d;
  assign bus.MemRead     = w_ctrl.mem_read;
  assign bus.MemWrite    = w_ctrl.mem_write;
  assign bus.IRWrite     = w_ctrl.ir_write;
  assign bus.MemtoReg    = w_ctrl.mem_to_reg;
  assign bus.RegDst      = w_ctrl.reg_dst;
  assign bus.RegWrite    = w_ctrl.reg_write;
  assign bus.ALUSrcA     = w_ctrl.alu_src_a;
  assign bus.ALUSrcB     = w_ctrl.alu_src_b;
  assign bus.ALUOp       = w_ctrl.alu_op;
  assign bus.PCSource    = w_ctrl.pc_source;
  assign bus.MemErr      = w_mem_err;
  assign bus.State       = Reset ? 4'd0 : r_state;

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  assign Illegal = !Reset && (r_state == S_TRAP);
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
//------------------------------------------------------------------------------
// tb_multicycle_control : randomized instruction stream against a cycle-plan model.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control;

  localparam int T = 4;

  typedef struct {
    int st;
    bit rdy;
    bit err;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  rec_t q[$];
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  logic illegal;
`endif

  multicycle_control_if bus ();

  multicycle_control #(
    .MEM_TIMEOUT (T),
    .CNT_W       (8)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    ,
    .Illegal (illegal)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] get_ctrl();
    return 32'({bus.PCWrite, bus.PCWriteCond, bus.BranchNe, bus.IorD, bus.MemRead,
                bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite,
                bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.MemErr});
  endfunction

  // Expected control word from the per-state output table.
  function automatic logic [31:0] exp_ctrl(int st, bit rdy, logic [5:0] op, bit err);
    bit pcw = 0, pcc = 0, bne = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
    bit m2r = 0, rdst = 0, rw = 0, sa = 0;
    logic [1:0] sb = 2'b00, aop = 2'b00, pcs = 2'b00;
    case (st)
      0: begin mrd = !err; if (rdy) begin irw = 1; pcw = 1; sb = 2'b01; end end
      1: sb = 2'b11;
      2: begin sa = 1; sb = 2'b10; end
      3: begin mrd = !err; iord = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mwr = !err; iord = 1; end
      6: begin sa = 1; aop = 2'b10; end
      7: begin rw = 1; rdst = 1; end
      8: begin sa = 1; sb = 2'b10; aop = 2'b11; end
      9: rw = 1;
      10: begin sa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; bne = (op == 6'b001001); end
      default: ;
    endcase
    return 32'({pcw, pcc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, aop, pcs, err});
  endfunction

  // One memory access: 'waits' not-ready cycles, then ready, unless the T-th wait times out.
  task automatic plan_access(input int st, input int waits, output bit aborted);
    aborted = 0;
    for (int k = 0; k < waits; k++) begin
      if (k == T - 1) begin
        q.push_back('{st, 1'b0, 1'b1});
        aborted = 1;
        return;
      end
      q.push_back('{st, 1'b0, 1'b0});
    end
    q.push_back('{st, 1'b1, 1'b0});
  endtask

  task automatic plan_instr(input logic [5:0] op, input int wf, input int wm);
    bit ab;
    plan_access(0, wf, ab);
    if (ab) plan_access(0, 0, ab);
    q.push_back('{1, 1'($urandom), 1'b0});
    case (op)
      6'b000000: begin q.push_back('{6, 1'($urandom), 1'b0}); q.push_back('{7, 1'($urandom), 1'b0}); end
      6'b000100, 6'b000110: begin
        q.push_back('{8, 1'($urandom), 1'b0}); q.push_back('{9, 1'($urandom), 1'b0});
      end
      6'b100011: begin
        q.push_back('{2, 1'($urandom), 1'b0});
        plan_access(3, wm, ab);
        if (!ab) q.push_back('{4, 1'($urandom), 1'b0});
      end
      6'b101011: begin q.push_back('{2, 1'($urandom), 1'b0}); plan_access(5, wm, ab); end
      6'b001000, 6'b001001: q.push_back('{10, 1'($urandom), 1'b0});
      default: ;
    endcase
  endtask

  task automatic run(input logic [5:0] op, input int ncyc, input int zero);
    rec_t r;
    int n = 0;
    while (q.size() > 0 && n < ncyc) begin
      r = q.pop_front();
      @(negedge clk);
      bus.Opcode   = op;
      bus.MemReady = r.rdy;
      bus.Zero     = (zero < 0) ? 1'($urandom) : 1'(zero);
      #2;
      check("state", 32'(bus.State), 32'(r.st));
      check("ctrl", get_ctrl(), exp_ctrl(r.st, r.rdy, op, r.err));
      n++;
    end
  endtask

  task automatic do_instr(input logic [5:0] op, input int wf, input int wm, input int zero);
    plan_instr(op, wf, wm);
    run(op, 1000, zero);
  endtask

  function automatic bit is_legal(logic [5:0] op);
    return op inside {6'b000000, 6'b000100, 6'b000110, 6'b100011, 6'b101011, 6'b001000, 6'b001001};
  endfunction

  initial begin
    logic [5:0] ops [7];
    logic [5:0] op;
    ops = '{6'b000000, 6'b000100, 6'b000110, 6'b100011, 6'b101011, 6'b001000, 6'b001001};
    bus.Opcode = 6'b100011; bus.MemReady = 1'b0; bus.Zero = 1'b0;

    // Power-up reset, then run an LW into a stalled MEMRD and reset it there.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    plan_instr(6'b100011, 0, 6);
    run(6'b100011, 5, -1);
    q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b1; bus.MemReady = 1'b0;
      #2;
      check("rst_ctrl", get_ctrl(), 32'd0);
      check("rst_state", 32'(bus.State), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("post_rst_state", 32'(bus.State), 32'd0);
    check("post_rst_memread", 32'(bus.MemRead), 32'd1);
    q.push_back('{0, 1'b1, 1'b0});
    run(6'b000000, 1, -1);
    q.push_back('{1, 1'b0, 1'b0});
    run(6'b000000, 1, -1);
    q.push_back('{6, 1'b1, 1'b0}); q.push_back('{7, 1'b0, 1'b0});
    run(6'b000000, 2, -1);

    // Directed cases from the plan.
    do_instr(6'b000000, 0, 0, -1);
    do_instr(6'b100011, 0, 2, -1);
    do_instr(6'b001001, 0, 0, 0);
    do_instr(6'b001000, 0, 0, 1);
    do_instr(6'b000100, T, 0, -1);
    do_instr(6'b101011, 1, T + 1, -1);
    do_instr(6'b100011, 0, T, -1);
`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    do_instr(6'b111111, 0, 0, -1);
`endif

    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 6)];
`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 7) == 0) begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end
`endif
      do_instr(op, ($urandom_range(0, 5) == 0) ? $urandom_range(0, 6) : 0,
               $urandom_range(0, 6), -1);
    end

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    plan_instr(6'b111111, 0, 0);
    run(6'b111111, 1000, -1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.MemReady = 1'($urandom);
      #2;
      check("trap_state", 32'(bus.State), 32'd11);
      check("trap_ctrl", get_ctrl(), 32'd0);
      check("trap_illegal", 32'(illegal), 32'd1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("trap_cleared", 32'(illegal), 32'd0);
    check("trap_reset_state", 32'(bus.State), 32'd0);
`else
    do_instr(6'b000000, 0, 0, -1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main sequencing FSM for the multicycle 16-bit CPU.
- Decodes the 6-bit instruction opcode and walks each instruction through fetch, decode, execute, memory and writeback.
- Each cycle it drives the datapath mux selects, register/PC/IR write enables and the 2-bit ALUOp that configures the ALU control decoder.
- Handshakes with the unified instruction/data memory and times out stalled accesses.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive cycles an access waits for MemReady before it is aborted (legal range 2..255).
- CNT_W, 8: width of the wait counter.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high. One clock; all state updates on the Clock rising edge.
- Opcode  in  6  IR[15:10].
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory access completes this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  conditional PC load (branch).
- BranchNe  out  1  branch condition select: 1 = load on !Zero, 0 = load on Zero.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  writeback data select: 1 = MDR, 0 = ALUOut.
- RegDst  out  1  destination register select: 1 = rd, 0 = rt.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B select: 00 = rt, 01 = const 1, 10 = imm, 11 = branch offset.
- ALUOp  out  2  00 = add, 01 = sub, 10 = R-format, 11 = I-format.
- PCSource  out  2  00 = ALU result, 01 = ALUOut.
- MemErr  out  1  one-cycle pulse on access timeout.
- State  out  4  current state, for debug.

Behaviour:
- Opcodes: R = 000000, ADDI = 000100, ANDI = 000110, LW = 100011, SW = 101011, BEQ = 001000, BNE = 001001.
- Control outputs:
  - Combinational from state, MemReady and Opcode.
  - Any output not listed for a state is 0.
  - While Reset = 1, every output is 0.
- Reset:
  - State <= FETCH and wait counter <= 0.
  - Reset asserted mid-instruction aborts it; no write enable is asserted in that cycle.
- FETCH (0):
  - MemRead = 1, IorD = 0.
  - If MemReady: IRWrite = 1, PCWrite = 1, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00; go to DECODE.
- DECODE (1):
  - ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00.
  - Next state: LW/SW -> MEMADR, R -> REXEC, ADDI/ANDI -> IEXEC, BEQ/BNE -> BRANCH.
  - Any other opcode -> FETCH (NOP).
- MEMADR (2):
  - ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00.
  - Next state: LW -> MEMRD, SW -> MEMWR.
- MEMRD (3):
  - MemRead = 1, IorD = 1.
  - If MemReady, go to MEMWB.
- MEMWB (4): RegWrite = 1, MemtoReg = 1, RegDst = 0; go to FETCH.
- MEMWR (5):
  - MemWrite = 1, IorD = 1.
  - If MemReady, go to FETCH.
- REXEC (6): ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10; go to RWB.
- RWB (7): RegWrite = 1, RegDst = 1, MemtoReg = 0; go to FETCH.
- IEXEC (8): ALUSrcA = 1, ALUSrcB = 10, ALUOp = 11; go to IWB.
- IWB (9): RegWrite = 1, RegDst = 0, MemtoReg = 0; go to FETCH.
- BRANCH (10):
  - ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01.
  - BranchNe = (Opcode == BNE).
  - Go to FETCH.
- Instruction latency with zero memory wait, in cycles: R/ADDI/ANDI 4, LW 5, SW 4, BEQ/BNE 3.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle spent in one of those states with MemReady = 0.
  - Saturates; never wraps.
- Timeout:
  - When the counter equals MEM_TIMEOUT-1 and MemReady = 0: MemErr = 1 for that cycle and the access request is dropped.
  - Next state is FETCH, which re-enters with the counter cleared.
  - An aborted MEMRD or MEMWR performs no register write.
- MemReady = 1 in the same cycle as the timeout condition: ready wins and there is no MemErr.
- MemReady outside FETCH/MEMRD/MEMWR is ignored.

Optional Feature:
- Macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
- When defined:
  - An undecoded opcode in DECODE goes to TRAP (11).
  - TRAP holds all enables at 0, drives output Illegal = 1 and is left only by Reset.
  - The Illegal port exists only under the macro.
- When undefined: undecoded opcodes execute as a 2-cycle NOP (FETCH, DECODE, FETCH).

Decomposition:
- Package cpu_ctrl_pkg: opcode constants, ALUOp encodings (ALUOP_ADD/SUB/RFMT/IFMT), ALUSrcB and PCSource encodings, state encodings.
- One natural sub-module, mem_wait_timer: counter, clear, saturate and timeout compare, parameterised by MEM_TIMEOUT.

Test Plan:
- Reset held 3 cycles mid-MEMRD, then released -> all outputs 0 during reset; State = 0 the cycle after release; MemRead = 1.
- R-format (Opcode 000000), MemReady always 1 -> State sequence 0,1,6,7,0; ALUOp = 10 in REXEC; RegWrite = 1 and RegDst = 1 only in RWB; 4 cycles total.
- LW with MemReady low for 2 cycles in MEMRD -> State 0,1,2,3,3,3,4,0; MemtoReg = 1 and RegWrite = 1 in MEMWB; MemErr stays 0.
- BNE with Zero = 0, then BEQ with Zero = 1 -> PCWriteCond = 1 in BRANCH, with BranchNe = 1 and 0 respectively; ALUOp = 01.
- MEM_TIMEOUT = 4, MemReady held 0 in FETCH -> MemErr pulses on the 4th wait cycle; FETCH re-entered; then MemReady = 1 -> IRWrite = 1.
- Opcode 111111 -> without the macro, State 0,1,0; with MULTICYCLE_CTRL_ILLEGAL_TRAP_EN, State = 11 and Illegal = 1 held until Reset.
